compare_seq_ctrl: RTL and testbench

//  Sequencer for a cascadable magnitude comparator. Compares two WIDTH-bit operands.
//  One shared SLICE-bit compare slice is time-multiplexed across the words, MSB slice first.

---
 rtl/compare_pkg.sv | 30 +++
 rtl/compare_slice.sv | 22 ++
 rtl/compare_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_compare_seq_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared definitions for the time-multiplexed magnitude comparator.
//   state_t          : sequencer states (IDLE, CMP)
//   NS_DEF, IDX_W_DEF: slice count / index width for the default 16/4 geometry
//   idx_width()      : index width for a given slice count (never below 1)
//   resolve_cascade(): {GT, LE, EQ} one-hot from the lower-order cascade inputs
package compare_pkg;

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    function automatic int unsigned idx_width(input int unsigned ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

    localparam int unsigned NS_DEF    = 16 / 4;
    localparam int unsigned IDX_W_DEF = idx_width(NS_DEF);

    // Priority IEQ > IGT > ILE; no cascade input at all resolves to equal.
    function automatic logic [2:0] resolve_cascade(input logic igt,
                                                   input logic ile,
                                                   input logic ieq);
        if (ieq)      return 3'b001;
        else if (igt) return 3'b100;
        else if (ile) return 3'b010;
        else          return 3'b001;
    endfunction

endpackage

// File: rtl/compare_slice.sv
// Combinational SLICE-bit unsigned magnitude compare.
//   a, b : slice operands
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module compare_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/compare_seq_ctrl.sv
// Sequencer for a cascadable magnitude comparator. One shared compare slice is
// walked from the MSB slice down, stopping at the first unequal slice; the
// cascade inputs decide only when every slice is equal.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request, honoured only while idle
//   A, B          : operands, captured on the accepted start edge
//   IGT, ILE, IEQ : cascade inputs, captured with A/B
//   busy          : compare in progress
//   done          : one-cycle pulse when FGT/FLE/FEQ are updated
//   FGT, FLE, FEQ : one-hot result, held until the next done
module compare_seq_ctrl
    import compare_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             IGT,
    input  logic             ILE,
    input  logic             IEQ,
    output logic             busy,
    output logic             done,
    output logic             FGT,
    output logic             FLE,
    output logic             FEQ
);

    localparam int unsigned NS = WIDTH / SLICE;
    localparam int unsigned IW = idx_width(NS);

    state_t           state, state_nx;
    logic [IW-1:0]    idx, idx_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             igt_q, ile_q, ieq_q;
    logic             load, finish;
    logic [2:0]       res_nx;

    logic [SLICE-1:0] sl_a, sl_b;
    logic             sl_gt, sl_lt, sl_eq;

    // Only the captured operands feed the slice, so input changes after the
    // start edge cannot disturb a running compare.
    assign sl_a = a_q[idx*SLICE +: SLICE];
    assign sl_b = b_q[idx*SLICE +: SLICE];

    compare_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .gt (sl_gt),
        .lt (sl_lt),
        .eq (sl_eq)
    );

    assign busy = (state == CMP);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        load     = 1'b0;
        finish   = 1'b0;
        res_nx   = {FGT, FLE, FEQ};
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    idx_nx   = IW'(NS - 1);
                    state_nx = CMP;
                end
            end
            CMP: begin
                if (!sl_eq) begin
                    res_nx   = {sl_gt, sl_lt, 1'b0};
                    finish   = 1'b1;
                    state_nx = IDLE;
                end else if (idx == '0) begin
                    res_nx   = resolve_cascade(igt_q, ile_q, ieq_q);
                    finish   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    idx_nx = idx - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            igt_q <= 1'b0;
            ile_q <= 1'b0;
            ieq_q <= 1'b0;
            FGT   <= 1'b0;
            FLE   <= 1'b0;
            FEQ   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            done  <= finish;
            if (load) begin
                a_q   <= A;
                b_q   <= B;
                igt_q <= IGT;
                ile_q <= ILE;
                ieq_q <= IEQ;
            end
            if (finish) begin
                {FGT, FLE, FEQ} <= res_nx;
            end
        end
    end

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Self-checking bench for compare_seq_ctrl: table of vectors plus hand-written
// back-to-back, start-while-busy and reset-abort sequences, all scored through
// an expected-result queue popped on each done pulse.
module tb_compare_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A, B;
    logic        IGT, ILE, IEQ;
    logic        busy, done, FGT, FLE, FEQ;

    compare_seq_ctrl #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .IGT   (IGT),
        .ILE   (ILE),
        .IEQ   (IEQ),
        .busy  (busy),
        .done  (done),
        .FGT   (FGT),
        .FLE   (FLE),
        .FEQ   (FEQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        igt;
        logic        ile;
        logic        ieq;
        logic [2:0]  exp_f;   // {FGT, FLE, FEQ}
        int          lat;
    } vec_t;

    typedef struct {
        logic [2:0] exp_f;
        int         lat;
        int         cs;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic [2:0] f_prev = 3'b000;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        sb_t e;
        @(posedge clk);
        #1;
        if (rst) begin
            f_prev = {FGT, FLE, FEQ};
        end else if (done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d got done=1 expected done=0", cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if ({FGT, FLE, FEQ} !== e.exp_f) begin
                    errors++;
                    $display("FAIL result cyc=%0d got FGT/FLE/FEQ=%b expected %b", cyc, {FGT, FLE, FEQ}, e.exp_f);
                end
                checks++;
                if (cyc - e.cs != e.lat) begin
                    errors++;
                    $display("FAIL latency cyc=%0d got %0d expected %0d", cyc, cyc - e.cs, e.lat);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_in_done cyc=%0d got %b expected 0", cyc, busy);
                end
            end
            f_prev = {FGT, FLE, FEQ};
        end else begin
            checks++;
            if ({FGT, FLE, FEQ} !== f_prev) begin
                errors++;
                $display("FAIL result_hold cyc=%0d got %b expected %b", cyc, {FGT, FLE, FEQ}, f_prev);
            end
        end
    end

    // Drive a request at the current time and queue its expected outcome.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic igt, input logic ile, input logic ieq,
                         input logic [2:0] exp_f, input int lat);
        sb_t e;
        A = a; B = b; IGT = igt; ILE = ile; IEQ = ieq;
        start = 1'b1;
        e.exp_f = exp_f; e.lat = lat; e.cs = cyc;
        sb.push_back(e);
    endtask

    task automatic release_start();
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d expected 0 after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    vec_t vecs[10];

    initial begin
        int d0;
        vecs[0] = '{16'hB001, 16'h4001, 1'b0, 1'b0, 1'b1, 3'b100, 2};
        vecs[1] = '{16'h8801, 16'h8C01, 1'b0, 1'b0, 1'b0, 3'b010, 3};
        vecs[2] = '{16'h8C20, 16'h8C10, 1'b0, 1'b0, 1'b0, 3'b100, 4};
        vecs[3] = '{16'h8C2F, 16'h8C2F, 1'b0, 1'b0, 1'b1, 3'b001, 5};
        vecs[4] = '{16'h8C2F, 16'h8C2F, 1'b1, 1'b0, 1'b0, 3'b100, 5};
        vecs[5] = '{16'h8C2F, 16'h8C2F, 1'b0, 1'b1, 1'b0, 3'b010, 5};
        vecs[6] = '{16'h8C2F, 16'h8C2F, 1'b0, 1'b0, 1'b0, 3'b001, 5};
        vecs[7] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1, 3'b001, 5};
        vecs[8] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 3'b010, 2};
        vecs[9] = '{16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b0, 3'b100, 5};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; IGT = 1'b0; ILE = 1'b0; IEQ = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({busy, done, FGT, FLE, FEQ} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state got %b expected 00000", {busy, done, FGT, FLE, FEQ});
        end
        rst = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].igt, vecs[i].ile, vecs[i].ieq,
                  vecs[i].exp_f, vecs[i].lat);
            release_start();
            wait_idle(20);
            @(posedge clk);
            #2;
        end

        // Back-to-back: second start driven in the done cycle of the first.
        issue(16'h8C20, 16'h8C10, 1'b0, 1'b0, 1'b0, 3'b100, 4);
        release_start();
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #2;
            if (done) begin
                issue(16'h8C2E, 16'h8C2F, 1'b0, 1'b0, 1'b0, 3'b010, 5);
                break;
            end
        end
        release_start();
        wait_idle(20);
        @(posedge clk);
        #2;

        // Start while busy: new operands and start must be ignored.
        d0 = done_cnt;
        issue(16'h8C2F, 16'h8C2F, 1'b0, 1'b0, 1'b1, 3'b001, 5);
        release_start();
        @(posedge clk);
        #2;
        A = 16'h0001; B = 16'hF000; IGT = 1'b1; IEQ = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_idle(20);
        repeat (6) @(posedge clk);
        #2;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL busy_start_done_count got %0d expected 1", done_cnt - d0);
        end

        // Reset on the 2nd CMP cycle aborts without a done.
        d0 = done_cnt;
        issue(16'h8C2F, 16'h8C2F, 1'b1, 1'b0, 1'b0, 3'b100, 5);
        release_start();
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if ({busy, done, FGT, FLE, FEQ} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_abort got %b expected 00000", {busy, done, FGT, FLE, FEQ});
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL reset_no_done got %0d dones expected 0", done_cnt - d0);
        end
        issue(16'h8C2F, 16'h8C21, 1'b0, 1'b0, 1'b0, 3'b100, 5);
        release_start();
        wait_idle(20);
        repeat (2) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
